// File: rtl/qspim_pkg.sv
// Shared types and phase lengths for the Wishbone to quad-SPI master bridge.
// QSPIM_SEL_EN adds a byte-enable nibble after the address phase.
package qspim_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_SEL, S_DUMMY,
        S_DATA_WR, S_DATA_RD, S_CS_HOLD, S_ACK
    } state_t;

    localparam int CMD_NIB  = 2;
    localparam int ADDR_NIB = 8;
    localparam int SEL_NIB  = 1;
    localparam int DATA_NIB = 8;

`ifdef QSPIM_SEL_EN
    localparam bit SEL_EN = 1'b1;
`else
    localparam bit SEL_EN = 1'b0;
`endif

endpackage

// File: rtl/qspim_sck_gen.sv
// SPI mode-0 clock divider: CLK_DIV sys_clk cycles per half period, idle low.
// rise/fall are high in the cycle whose closing edge moves sck.
module qspim_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam int DIVW = $clog2(CLK_DIV + 1);

    logic [DIVW-1:0] cnt;
    logic            tick;

    assign tick = en && (cnt == DIVW'(CLK_DIV - 1));
    assign rise = tick & ~sck;
    assign fall = tick & sck;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qspim_wb.sv
// Wishbone slave to quad-SPI master: each single read/write becomes one
// CMD/ADDR/[SEL]/[DUMMY]/DATA frame. Macro QSPIM_SEL_EN enables the SEL nibble.
module qspim_wb
    import qspim_pkg::*;
#(
    parameter int          CLK_DIV   = 2,
    parameter int          DUMMY_NIB = 4,
    parameter logic [7:0]  CMD_WR    = 8'h02,
    parameter logic [7:0]  CMD_RD    = 8'h0B
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        spi_sck,
    output logic        spi_csn,
    output logic [3:0]  spi_sdo,
    input  logic [3:0]  spi_sdi,
    output logic        spi_oen,
    output logic        busy
);
    localparam int DIVW = $clog2(CLK_DIV + 1);
`ifdef QSPIM_SEL_EN
    localparam int SHW = 76;
`else
    localparam int SHW = 72;
`endif

    state_t          state, nxt, ns;
    logic [3:0]      nib, last;
    logic [SHW-1:0]  sh, frame;
    logic [31:0]     rd_sh;
    logic [7:0]      cmd;
    logic [DIVW-1:0] hold;
    logic            we, drop, req, sck_en, rise, fall, ack_ok;

    assign cmd    = wbs_we_i ? CMD_WR : CMD_RD;
    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
    assign sck_en = state inside {S_CS_SETUP, S_CMD, S_ADDR, S_SEL, S_DUMMY, S_DATA_WR, S_DATA_RD};
    assign busy   = (state != S_IDLE);
    assign ack_ok = ~drop & wbs_cyc_i;

    // First command nibble goes straight to sdo; the rest queue up MSB-first.
`ifdef QSPIM_SEL_EN
    assign frame = {cmd[3:0], wbs_adr_i, wbs_sel_i, wbs_dat_i, 4'h0};
`else
    assign frame = {cmd[3:0], wbs_adr_i, wbs_dat_i, 4'h0};
    logic unused_sel;
    assign unused_sel = ^wbs_sel_i;
`endif

    always_comb begin
        nxt  = S_CS_HOLD;
        last = 4'(DATA_NIB - 1);
        case (state)
            S_CMD:   begin last = 4'(CMD_NIB - 1);   nxt = S_ADDR; end
            S_ADDR:  begin last = 4'(ADDR_NIB - 1);
                           nxt  = SEL_EN ? S_SEL : (we ? S_DATA_WR : S_DUMMY); end
            S_SEL:   begin last = 4'(SEL_NIB - 1);   nxt = we ? S_DATA_WR : S_DUMMY; end
            S_DUMMY: begin last = 4'(DUMMY_NIB - 1); nxt = S_DATA_RD; end
            default: ;
        endcase
        ns = (nib == last) ? nxt : state;
    end

    qspim_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .en      (sck_en),
        .sck     (spi_sck),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            spi_csn   <= 1'b1;
            spi_sdo   <= 4'h0;
            spi_oen   <= 1'b1;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
            nib       <= '0;
            sh        <= '0;
            rd_sh     <= '0;
            hold      <= '0;
            we        <= 1'b0;
            drop      <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            if (busy && !wbs_cyc_i) drop <= 1'b1;
            case (state)
                S_IDLE: if (req) begin
                    if (wbs_adr_i[1:0] != 2'b00) begin
                        wbs_err_o <= 1'b1;
                    end else begin
                        state   <= S_CS_SETUP;
                        we      <= wbs_we_i;
                        drop    <= 1'b0;
                        sh      <= frame;
                        spi_sdo <= cmd[7:4];
                        spi_csn <= 1'b0;
                        spi_oen <= 1'b0;
                    end
                end
                S_CS_SETUP: if (rise) begin
                    state <= S_CMD;
                    nib   <= '0;
                end
                S_CS_HOLD: begin
                    if (hold == DIVW'(CLK_DIV - 1)) begin
                        state     <= S_ACK;
                        wbs_ack_o <= ack_ok;
                        if (!we && ack_ok) wbs_dat_o <= rd_sh;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                S_ACK: state <= S_IDLE;
                default: begin
                    if (rise && state == S_DATA_RD) rd_sh <= {rd_sh[27:0], spi_sdi};
                    if (fall) begin
                        state <= ns;
                        nib   <= (nib == last) ? 4'd0 : nib + 4'd1;
                        if (ns == S_CS_HOLD) begin
                            spi_csn <= 1'b1;
                            spi_oen <= 1'b1;
                            spi_sdo <= 4'h0;
                            hold    <= '0;
                        end else if (ns == S_DUMMY || ns == S_DATA_RD) begin
                            spi_oen <= 1'b1;
                            spi_sdo <= 4'h0;
                        end else begin
                            spi_sdo <= sh[SHW-1 -: 4];
                            sh      <= sh << 4;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspim_wb.sv
// Bench for qspim_wb: responder model on the SPI pins, table + random WB transfers,
// and hand-written reset / cyc-drop / back-to-back sequences.
module tb_qspim_wb;
    localparam int CLK_DIV   = 2;
    localparam int DUMMY_NIB = 4;
`ifdef QSPIM_SEL_EN
    localparam int SELN = 1;
`else
    localparam int SELN = 0;
`endif
    localparam int HDR = 10 + SELN;

    logic        sys_clk = 1'b0, rst_n = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0, wbs_dat_o;
    logic [3:0]  wbs_sel_i = '0, spi_sdo, spi_sdi = '0;
    logic        wbs_ack_o, wbs_err_o, spi_sck, spi_csn, spi_oen, busy;

    always #5 sys_clk = ~sys_clk;

    qspim_wb #(.CLK_DIV(CLK_DIV), .DUMMY_NIB(DUMMY_NIB)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi),
        .spi_oen(spi_oen), .busy(busy)
    );

    typedef struct {
        logic [3:0] sdo;
        logic       oen;
        logic       csn;
    } mon_t;

    typedef struct {
        logic        we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic [31:0] rdw;
        logic        exp_err;
        int          exp_rises;
    } vec_t;

    int          n_cmp = 0, n_bad = 0;
    mon_t        mon_q[$];
    int          base = 0;
    logic [31:0] rd_word = '0;

    // Bus snapshot at every SCK rise; the count of rises so far indexes the nibble.
    always @(posedge spi_sck) mon_q.push_back('{spi_sdo, spi_oen, spi_csn});

    // Responder: after each fall, put the next read-data nibble on sdi (junk otherwise).
    always @(negedge spi_sck) begin
        int idx;
        idx = mon_q.size() - base - HDR - DUMMY_NIB;
        if (idx >= 0 && idx < 8) spi_sdi = 4'(rd_word >> (28 - 4 * idx));
        else spi_sdi = 4'($urandom);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Expected nibble i of a frame, straight from the frame layout.
    function automatic logic [3:0] exp_nib(input logic we, input logic [31:0] adr, dat,
                                           input logic [3:0] sel, input int i);
        logic [7:0] cmd;
        cmd = we ? 8'h02 : 8'h0B;
        if (i < 2) return 4'(cmd >> (4 * (1 - i)));
        if (i < 10) return 4'(adr >> (4 * (9 - i)));
        if (SELN == 1 && i == 10) return sel;
        return 4'(dat >> (4 * (HDR + 7 - i)));
    endfunction

    function automatic int frame_len(input logic we, input logic [31:0] adr);
        if (adr[1:0] != 2'b00) return 0;
        return HDR + 8 + (we ? 0 : DUMMY_NIB);
    endfunction

    task automatic xfer(input vec_t v, input string tag);
        int acks = 0, errs = 0, cyc = 0, n;
        logic csn_low = 1'b0;
        logic [31:0] got_dat = '0;
        base = mon_q.size();
        rd_word = v.rdw;
        @(negedge sys_clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = v.we;
        wbs_adr_i = v.adr; wbs_dat_i = v.dat; wbs_sel_i = v.sel;
        while (cyc < 3000 && acks + errs == 0) begin
            @(posedge sys_clk); #1; cyc++;
            if (!spi_csn) csn_low = 1'b1;
            if (wbs_ack_o) begin acks++; got_dat = wbs_dat_o; end
            if (wbs_err_o) errs++;
        end
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(posedge sys_clk); #1;
        if (wbs_ack_o) acks++;
        if (wbs_err_o) errs++;
        chk({tag, " responded"}, 64'(acks + errs > 0), 1);
        chk({tag, " err_cycles"}, 64'(errs), 64'(v.exp_err));
        chk({tag, " ack_cycles"}, 64'(acks), 64'(!v.exp_err));
        n = mon_q.size() - base;
        chk({tag, " sck_rises"}, 64'(n), 64'(v.exp_rises));
        if (v.exp_err) chk({tag, " csn_stayed_high"}, 64'(csn_low), 0);
        for (int i = 0; i < n && i < v.exp_rises; i++) begin
            logic       eo;
            logic [3:0] es, gs;
            eo = !v.we && i >= HDR;
            es = eo ? 4'h0 : exp_nib(v.we, v.adr, v.dat, v.sel, i);
            gs = eo ? 4'h0 : mon_q[base + i].sdo;
            chk($sformatf("%s nibble%0d {oen,csn,sdo}", tag, i),
                {mon_q[base + i].oen, mon_q[base + i].csn, gs}, {eo, 1'b0, es});
        end
        if (!v.we && !v.exp_err) chk({tag, " dat_o"}, got_dat, v.rdw);
    endtask

    vec_t tbl[7];

    initial begin
        int t, acks, gap, n;
        vec_t v;
        tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, HDR + 8};
        tbl[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h1234_5678, 1'b0, HDR + 8 + DUMMY_NIB};
        tbl[2] = '{1'b1, 32'h0000_0022, 32'h1111_1111, 4'hF, 32'h0, 1'b1, 0};
        tbl[3] = '{1'b0, 32'h0000_0001, 32'h0,         4'hF, 32'h0, 1'b1, 0};
        tbl[4] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, HDR + 8};
        tbl[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'hFFFF_FFFF, 1'b0, HDR + 8 + DUMMY_NIB};
        tbl[6] = '{1'b0, 32'h0000_0000, 32'h0,         4'h5, 32'h0000_0000, 1'b0, HDR + 8 + DUMMY_NIB};

        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset csn", spi_csn, 1);   chk("reset sck", spi_sck, 0);
        chk("reset sdo", spi_sdo, 0);   chk("reset oen", spi_oen, 1);
        chk("reset ack", wbs_ack_o, 0); chk("reset err", wbs_err_o, 0);
        chk("reset dat_o", wbs_dat_o, 0); chk("reset busy", busy, 0);
        @(negedge sys_clk); rst_n = 1;

        foreach (tbl[i]) xfer(tbl[i], $sformatf("tbl%0d", i));

        for (int r = 0; r < 20; r++) begin
            v.we  = 1'($urandom);
            v.adr = $urandom;
            if ($urandom_range(0, 5) != 0) v.adr[1:0] = 2'b00;
            v.dat = $urandom; v.sel = 4'($urandom); v.rdw = $urandom;
            v.exp_err = (v.adr[1:0] != 2'b00);
            v.exp_rises = frame_len(v.we, v.adr);
            xfer(v, $sformatf("rnd%0d", r));
        end

        // Reset pulse while ADDR nibble 4 (frame nibble 6) is on the wire.
        base = mon_q.size();
        @(negedge sys_clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h40; wbs_dat_i = 32'hCAFE_F00D;
        t = 0;
        while (mon_q.size() - base < 7 && t < 2000) begin @(posedge sys_clk); t++; end
        chk("rst reached addr nibble 4", 64'(mon_q.size() - base), 7);
        #3; rst_n = 0; #1;
        chk("midrst csn", spi_csn, 1); chk("midrst sck", spi_sck, 0);
        chk("midrst oen", spi_oen, 1); chk("midrst busy", busy, 0);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        acks = 0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1;
        repeat (20) begin @(posedge sys_clk); #1; if (wbs_ack_o) acks++; end
        chk("midrst no ack", 64'(acks), 0);
        xfer('{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, HDR + 8}, "post_rst");

        // cyc dropped mid-frame: the frame still finishes on the wire, without ack.
        base = mon_q.size();
        @(negedge sys_clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h80;
        t = 0; acks = 0;
        while (mon_q.size() - base < 5 && t < 2000) begin @(posedge sys_clk); t++; end
        @(negedge sys_clk); wbs_cyc_i = 0; wbs_stb_i = 0;
        t = 0;
        while (busy && t < 3000) begin @(posedge sys_clk); #1; t++; if (wbs_ack_o) acks++; end
        chk("cycdrop finished", 64'(busy), 0);
        chk("cycdrop no ack", 64'(acks), 0);
        chk("cycdrop rises", 64'(mon_q.size() - base), 64'(HDR + 8 + DUMMY_NIB));

        // Back-to-back writes with stb held throughout.
        base = mon_q.size();
        @(negedge sys_clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h100; wbs_dat_i = 32'hA5A5_5A5A;
        t = 0; acks = 0; gap = 0;
        while (acks < 2 && t < 4000) begin
            @(posedge sys_clk); #1; t++;
            if (wbs_ack_o) acks++;
            if (acks == 1 && spi_csn) gap++;
        end
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(posedge sys_clk); #1;
        if (wbs_ack_o) acks++;
        n = mon_q.size() - base;
        chk("b2b acks", 64'(acks), 2);
        chk("b2b csn gap >= 1", 64'(gap >= 1), 1);
        chk("b2b rises", 64'(n), 64'(2 * (HDR + 8)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
